controller_serial_multi: RTL and testbench
==========================================

Name: controller_serial_multi

Overview:
- Parametrised successor to the single-pad NES reader. Polls up to NUM_PADS shift-register gamepads (NES 8-bit or SNES 16-bit) over one shared latch/pulse pair, with one data line per pad.
- Generates its own bit timing from the system clock. Supports software-triggered and free-running auto-poll.
- Publishes debounced-per-frame button words plus one-cycle "pressed" edge flags to game logic (pacman movement, start/pause).

Parameters:
- NUM_PADS, 2, number of pads sharing latch/pulse (1..4).
- NUM_BITS, 8, bits shifted per pad; 8 = NES, 16 = SNES.
- HALF_PERIOD, 300, clk cycles per timing tick (6 us at 50 MHz); must be >= 4.
- POLL_TICKS, 2778, ticks between auto-poll starts (~60 Hz at 6 us ticks); must be > 2*NUM_BITS+2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  poll request; rising edge is used (asynchronous source allowed)
- auto_en  in  1  1 = free-running polling every POLL_TICKS ticks
- data_in  in  NUM_PADS  serial data per pad, active-low (0 = pressed)
- latch_out  out  1  latch to all pads
- pulse_out  out  1  shift clock to all pads
- buttons_out  out  NUM_PADS*NUM_BITS  pad p bit k at [p*NUM_BITS+k]; 1 = pressed; bit 0 is the first bit shifted (NES: A)
- pressed_out  out  NUM_PADS*NUM_BITS  one-cycle flags, bit newly pressed this frame
- valid_out  out  1  one-cycle strobe when buttons_out/pressed_out update
- busy_out  out  1  poll in progress

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0; FSM to IDLE; tick, bit and poll counters 0; pending 0; synchronisers cleared. Reset mid-poll aborts immediately, with latch and pulse low the next cycle.
- Tick generator: counter 0..HALF_PERIOD-1, runs only while busy. tick = 1 for one cycle at terminal count.
- Synchronisers: start and each data_in pass through a 2-flop synchroniser. The start edge is taken from the synchronised value (prev 0, now 1).
- FSM states: IDLE, LATCH, SHIFT, COMMIT.
- IDLE -> LATCH when a start edge occurs, pending=1, or (auto_en and poll counter wrapped). Tick counter clears on entry.
- LATCH: latch_out=1, pulse_out=0 for exactly 2 ticks, then -> SHIFT with bit index 0.
- SHIFT: each bit takes 2 ticks.
  - Low phase (pulse_out=0): at its closing tick, sample ~data_sync[p] into shift reg bit [idx] for every pad.
  - High phase (pulse_out=1): at its closing tick, idx++.
  - After idx = NUM_BITS-1 high phase -> COMMIT.
  - latch_out=0 throughout.
- COMMIT (1 cycle): buttons_out <= shift regs; pressed_out <= shift & ~old buttons_out; valid_out=1; -> IDLE. pressed_out and valid_out return to 0 the next cycle.
- Poll duration: 2+2*NUM_BITS ticks plus 1 cycle. busy_out=1 from LATCH entry through COMMIT inclusive.
- A start edge while busy sets pending. Exactly one extra poll starts after COMMIT; further edges while pending are absorbed.
- Auto poll: counts ticks of a free-running auto timer (runs only when auto_en=1). Wrap while busy sets pending.
- auto_en falling mid-poll: the current poll completes; no new auto start.
- Simultaneous start edge and auto wrap in IDLE: one poll only.
- Disconnected pad (data_in held 1 by pull-up): all bits read 0 (released).
- Width: bit index is $clog2(NUM_BITS) bits; tick counter is $clog2(HALF_PERIOD) bits; no arithmetic overflow permitted.

Decomposition:
- Package controller_pkg: FSM state enum (IDLE, LATCH, SHIFT, COMMIT) and button index constants for NES (BTN_A=0, BTN_B, BTN_SELECT, BTN_START, BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT).
- Sub-module controller_tick_gen: parametrised divider with enable and a synchronous clear, producing tick.

Test Plan (NUM_PADS=2, NUM_BITS=8, HALF_PERIOD=4, POLL_TICKS=40):
- Reset mid-SHIFT (rst_n low 1 cycle at bit 3) -> next cycle latch_out=0, pulse_out=0, busy_out=0, buttons_out=0; no valid_out.
- Single start edge, pad0 serial 0,1,1,1,1,1,1,0 (A and Right pressed), pad1 all 1 -> latch high exactly 8 cycles; 8 pulses of 4 high/4 low; valid_out one cycle at poll end; buttons_out=16'h0081; pressed_out=16'h0081; busy_out spans 73 cycles.
- Second poll with the same data -> buttons_out=16'h0081, pressed_out=0. Third poll with pad0 A released, pad1 Start pressed -> buttons_out=16'h0880, pressed_out=16'h0800.
- Start edge during SHIFT plus another during the same poll -> exactly one extra poll begins the cycle after COMMIT; total two valid_out strobes.
- auto_en=1, start held 0 -> LATCH entries spaced exactly 40 ticks (160 cycles); clearing auto_en mid-poll completes that poll, and no further latch pulses follow.
- Pads disconnected (data_in=2'b11) -> buttons_out=0, pressed_out=0, valid_out still strobes.

Source files
------------

// File: rtl/controller_serial_multi_pkg.sv
// Shared types for the multi-pad serial controller reader: FSM states and
// NES button bit positions within one pad's button word.
package controller_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LATCH  = 2'd1,
    SHIFT  = 2'd2,
    COMMIT = 2'd3
  } ctrl_state_e;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/controller_serial_multi_if.sv
// Bundle of the poll request, pad wiring and game-side button outputs.
// The controller takes the master view; stimulus/pad models take the slave view.
interface controller_serial_multi_if #(
  parameter int NUM_PADS = 2,
  parameter int NUM_BITS = 8
);
  logic                         start;
  logic                         auto_en;
  logic [NUM_PADS-1:0]          data_in;
  logic                         latch_out;
  logic                         pulse_out;
  logic [NUM_PADS*NUM_BITS-1:0] buttons_out;
  logic [NUM_PADS*NUM_BITS-1:0] pressed_out;
  logic                         valid_out;
  logic                         busy_out;

  modport master (
    input  start, auto_en, data_in,
    output latch_out, pulse_out, buttons_out, pressed_out, valid_out, busy_out
  );

  modport slave (
    output start, auto_en, data_in,
    input  latch_out, pulse_out, buttons_out, pressed_out, valid_out, busy_out
  );
endinterface

// File: rtl/controller_serial_multi_tick_gen.sv
// Clock divider: one-cycle tick every HALF_PERIOD enabled cycles, restartable
// from zero through a synchronous clear.
module controller_tick_gen #(
  parameter int HALF_PERIOD = 300
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(HALF_PERIOD);
  localparam logic [CW-1:0] TERM = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt_r;

  // Divider counter, wraps explicitly at the terminal count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      if (cnt_r == TERM) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tick = en && !clr && (cnt_r == TERM);
endmodule

// File: rtl/controller_serial_multi.sv
// Polls NUM_PADS shift-register gamepads over a shared latch/pulse pair and
// publishes per-frame button words plus newly-pressed flags.
module controller_serial_multi
  import controller_pkg::*;
#(
  parameter int NUM_PADS    = 2,
  parameter int NUM_BITS    = 8,
  parameter int HALF_PERIOD = 300,
  parameter int POLL_TICKS  = 2778
) (
  input  logic clk,
  input  logic rst_n,
  controller_serial_multi_if.master bus
);
  localparam int W      = NUM_PADS * NUM_BITS;
  localparam int IDX_W  = $clog2(NUM_BITS);
  localparam int PCNT_W = $clog2(POLL_TICKS);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_BITS - 1);
  localparam logic [PCNT_W-1:0] LAST_POLL = PCNT_W'(POLL_TICKS - 1);

  ctrl_state_e state_r, state_s;
  logic        ph_r, ph_s;
  logic [IDX_W-1:0] idx_r;
  logic [NUM_PADS-1:0][NUM_BITS-1:0] shift_r;
  logic        pending_r;
  logic [PCNT_W-1:0] poll_cnt_r;

  logic start_meta_r, start_sync_r, start_prev_r;
  logic [NUM_PADS-1:0] data_meta_r, data_sync_r;

  logic latch_r, pulse_r, valid_r, busy_r;
  logic [W-1:0] buttons_r, pressed_r;

  logic tick_s, auto_tick_s, start_edge_s, auto_wrap_s, busy_s;

  // Two-flop synchronisers for the asynchronous start and pad data lines
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_meta_r <= 1'b0;
      start_sync_r <= 1'b0;
      start_prev_r <= 1'b0;
      data_meta_r  <= '0;
      data_sync_r  <= '0;
    end else begin
      start_meta_r <= bus.start;
      start_sync_r <= start_meta_r;
      start_prev_r <= start_sync_r;
      data_meta_r  <= bus.data_in;
      data_sync_r  <= data_meta_r;
    end
  end

  assign start_edge_s = start_sync_r & ~start_prev_r;
  assign busy_s       = (state_r != IDLE);

  controller_tick_gen #(.HALF_PERIOD(HALF_PERIOD)) u_bit_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (busy_s),
    .clr   (state_r == IDLE),
    .tick  (tick_s)
  );

  // The auto timer free-runs independently of polls so spacing stays exact
  controller_tick_gen #(.HALF_PERIOD(HALF_PERIOD)) u_auto_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.auto_en),
    .clr   (!bus.auto_en),
    .tick  (auto_tick_s)
  );

  assign auto_wrap_s = bus.auto_en && auto_tick_s && (poll_cnt_r == LAST_POLL);

  // Auto-poll tick counter, held at zero whenever auto polling is off
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      poll_cnt_r <= '0;
    end else if (!bus.auto_en) begin
      poll_cnt_r <= '0;
    end else if (auto_tick_s) begin
      if (poll_cnt_r == LAST_POLL) begin
        poll_cnt_r <= '0;
      end else begin
        poll_cnt_r <= poll_cnt_r + PCNT_W'(1);
      end
    end else begin
      poll_cnt_r <= poll_cnt_r;
    end
  end

  // Next-state and half-bit phase; each LATCH/SHIFT step spans two ticks
  always_comb begin
    state_s = state_r;
    ph_s    = ph_r;
    case (state_r)
      IDLE: begin
        ph_s = 1'b0;
        if (start_edge_s || pending_r || auto_wrap_s) begin
          state_s = LATCH;
        end else begin
          state_s = IDLE;
        end
      end
      LATCH: begin
        if (tick_s) begin
          ph_s = ~ph_r;
        end else begin
          ph_s = ph_r;
        end
        if (tick_s && ph_r) begin
          state_s = SHIFT;
        end else begin
          state_s = LATCH;
        end
      end
      SHIFT: begin
        if (tick_s) begin
          ph_s = ~ph_r;
        end else begin
          ph_s = ph_r;
        end
        if (tick_s && ph_r && (idx_r == LAST_IDX)) begin
          state_s = COMMIT;
        end else begin
          state_s = SHIFT;
        end
      end
      COMMIT: begin
        ph_s    = 1'b0;
        state_s = IDLE;
      end
      default: begin
        ph_s    = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State, shift datapath and registered outputs derived from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      ph_r      <= 1'b0;
      idx_r     <= '0;
      shift_r   <= '0;
      pending_r <= 1'b0;
      latch_r   <= 1'b0;
      pulse_r   <= 1'b0;
      busy_r    <= 1'b0;
      valid_r   <= 1'b0;
      buttons_r <= '0;
      pressed_r <= '0;
    end else begin
      state_r <= state_s;
      ph_r    <= ph_s;

      // Data is active-low on the wire; sample at the close of the low phase
      if ((state_r == SHIFT) && tick_s && !ph_r) begin
        for (int p = 0; p < NUM_PADS; p++) begin
          shift_r[p][idx_r] <= ~data_sync_r[p];
        end
      end else begin
        shift_r <= shift_r;
      end

      if (state_r != SHIFT) begin
        idx_r <= '0;
      end else if (tick_s && ph_r && (idx_r != LAST_IDX)) begin
        idx_r <= idx_r + IDX_W'(1);
      end else begin
        idx_r <= idx_r;
      end

      if ((state_r == IDLE) && (state_s == LATCH)) begin
        pending_r <= 1'b0;
      end else if (busy_s && (start_edge_s || auto_wrap_s)) begin
        pending_r <= 1'b1;
      end else begin
        pending_r <= pending_r;
      end

      latch_r <= (state_s == LATCH);
      pulse_r <= (state_s == SHIFT) && ph_s;
      busy_r  <= (state_s != IDLE);

      if (state_s == COMMIT) begin
        buttons_r <= shift_r;
        pressed_r <= shift_r & ~buttons_r;
        valid_r   <= 1'b1;
      end else begin
        buttons_r <= buttons_r;
        pressed_r <= '0;
        valid_r   <= 1'b0;
      end
    end
  end

  assign bus.latch_out   = latch_r;
  assign bus.pulse_out   = pulse_r;
  assign bus.busy_out    = busy_r;
  assign bus.valid_out   = valid_r;
  assign bus.buttons_out = buttons_r;
  assign bus.pressed_out = pressed_r;
endmodule

// File: tb/tb_controller_serial_multi.sv
// Directed bench for controller_serial_multi with a behavioural NES pad model
// on each data line (bit k presented after k pulse rising edges).
module tb_controller_serial_multi;
  import controller_pkg::*;

  localparam int NP = 2;
  localparam int NB = 8;
  localparam int HP = 4;
  localparam int PT = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  controller_serial_multi_if #(.NUM_PADS(NP), .NUM_BITS(NB)) bus ();

  controller_serial_multi #(
    .NUM_PADS(NP), .NUM_BITS(NB), .HALF_PERIOD(HP), .POLL_TICKS(PT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Pad model: serial patterns are active-low, bit k shifted k-th
  logic [NB-1:0] serial0 = 8'hFF;
  logic [NB-1:0] serial1 = 8'hFF;
  int   pos = 0;
  logic pulse_q = 1'b0;

  function automatic logic pad_bit(input logic [NB-1:0] s, input int k);
    if (k < NB) return s[k[2:0]];
    else        return 1'b1;
  endfunction

  always @(posedge clk) begin
    pulse_q <= bus.pulse_out;
    if (bus.latch_out) pos <= 0;
    else if (bus.pulse_out && !pulse_q) pos <= pos + 1;
  end

  assign bus.data_in = {pad_bit(serial1, pos), pad_bit(serial0, pos)};

  // Free-running monitor counters sampled away from the active edge
  int cyc = 0, latch_cyc = 0, busy_cyc = 0, phi_cyc = 0, prise = 0;
  int valid_cnt = 0, lrise = 0, last_rise = 0, prev_rise = 0;
  logic pulse_m = 1'b0, latch_m = 1'b0;

  always @(negedge clk) begin
    cyc     <= cyc + 1;
    pulse_m <= bus.pulse_out;
    latch_m <= bus.latch_out;
    if (bus.latch_out) latch_cyc <= latch_cyc + 1;
    if (bus.busy_out)  busy_cyc  <= busy_cyc + 1;
    if (bus.pulse_out) phi_cyc   <= phi_cyc + 1;
    if (bus.pulse_out && !pulse_m) prise <= prise + 1;
    if (bus.valid_out) valid_cnt <= valid_cnt + 1;
    if (bus.latch_out && !latch_m) begin
      lrise     <= lrise + 1;
      prev_rise <= last_rise;
      last_rise <= cyc;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int max, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (bus.valid_out) seen = 1'b1;
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Single start edge, check the committed words at the valid strobe
  task automatic poll(input string tag, input logic [15:0] exp_b, input logic [15:0] exp_p);
    bit seen;
    bus.start = 1'b1;
    wait_valid(200, seen);
    check_eq({tag, "_valid"}, 32'(seen), 32'd1);
    check_eq({tag, "_buttons"}, 32'(bus.buttons_out), 32'(exp_b));
    check_eq({tag, "_pressed"}, 32'(bus.pressed_out), 32'(exp_p));
    bus.start = 1'b0;
    wait_cycles(6);
  endtask

  int  s_latch, s_busy, s_phi, s_prise, s_valid, s_lrise, gap;
  bit  seen;

  initial begin
    bus.start   = 1'b0;
    bus.auto_en = 1'b0;
    wait_cycles(3);
    check_eq("rst_ctrl", {28'd0, bus.latch_out, bus.pulse_out, bus.busy_out, bus.valid_out}, 32'd0);
    check_eq("rst_buttons", 32'(bus.buttons_out), 32'd0);
    check_eq("rst_pressed", 32'(bus.pressed_out), 32'd0);
    rst_n = 1'b1;
    wait_cycles(2);

    // Reset in the low phase of bit 3 aborts the poll at once
    serial0 = ~((8'd1 << BTN_A) | (8'd1 << BTN_RIGHT));
    serial1 = 8'hFF;
    s_prise = prise;
    bus.start = 1'b1;
    for (int i = 0; i < 200 && (prise - s_prise) < 3; i++) @(negedge clk);
    check_eq("mid_rises", 32'(prise - s_prise), 32'd3);
    bus.start = 1'b0;
    wait_cycles(6);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("mid_rst_ctrl", {29'd0, bus.latch_out, bus.pulse_out, bus.busy_out}, 32'd0);
    check_eq("mid_rst_buttons", 32'(bus.buttons_out), 32'd0);
    s_valid = valid_cnt;
    s_busy  = busy_cyc;
    wait_cycles(100);
    check_eq("mid_rst_no_valid", 32'(valid_cnt - s_valid), 32'd0);
    check_eq("mid_rst_no_busy", 32'(busy_cyc - s_busy), 32'd0);

    // First poll: A and Right on pad 0, pad 1 idle; check waveform shape
    s_latch = latch_cyc; s_busy = busy_cyc; s_phi = phi_cyc;
    s_prise = prise; s_valid = valid_cnt;
    poll("p1", 16'h0081, 16'h0081);
    check_eq("p1_latch_cycles", 32'(latch_cyc - s_latch), 32'd8);
    check_eq("p1_pulse_rises", 32'(prise - s_prise), 32'd8);
    check_eq("p1_pulse_high", 32'(phi_cyc - s_phi), 32'd32);
    check_eq("p1_busy_cycles", 32'(busy_cyc - s_busy), 32'd73);
    check_eq("p1_valid_count", 32'(valid_cnt - s_valid), 32'd1);

    poll("p2", 16'h0081, 16'h0000);

    serial0 = ~(8'd1 << BTN_RIGHT);
    serial1 = ~(8'd1 << BTN_START);
    poll("p3", 16'h0880, 16'h0800);

    // Two further start edges during one poll queue exactly one extra poll
    s_valid = valid_cnt; s_lrise = lrise; s_prise = prise;
    bus.start = 1'b1;
    for (int i = 0; i < 200 && (prise - s_prise) < 2; i++) @(negedge clk);
    bus.start = 1'b0; wait_cycles(4);
    bus.start = 1'b1; wait_cycles(4);
    bus.start = 1'b0; wait_cycles(4);
    bus.start = 1'b1; wait_cycles(4);
    bus.start = 1'b0;
    wait_valid(200, seen);
    check_eq("pend_valid1", 32'(seen), 32'd1);
    @(negedge clk);
    check_eq("pend_idle_gap", {30'd0, bus.busy_out, bus.latch_out}, 32'd0);
    @(negedge clk);
    check_eq("pend_relatch", 32'(bus.latch_out), 32'd1);
    wait_valid(200, seen);
    check_eq("pend_valid2", 32'(seen), 32'd1);
    check_eq("pend_pressed2", 32'(bus.pressed_out), 32'd0);
    wait_cycles(200);
    check_eq("pend_valid_total", 32'(valid_cnt - s_valid), 32'd2);
    check_eq("pend_latch_total", 32'(lrise - s_lrise), 32'd2);

    // Auto polling: LATCH entries 40 ticks apart; clearing mid-poll finishes it
    serial0 = ~(8'd1 << BTN_A);
    serial1 = 8'hFF;
    s_lrise = lrise;
    bus.auto_en = 1'b1;
    for (int i = 0; i < 400 && (lrise - s_lrise) < 2; i++) @(negedge clk);
    @(negedge clk);
    check_eq("auto_two_latches", 32'(lrise - s_lrise), 32'd2);
    gap = last_rise - prev_rise;
    check_eq("auto_spacing", 32'(gap), 32'(PT * HP));
    wait_cycles(20);
    bus.auto_en = 1'b0;
    wait_valid(100, seen);
    check_eq("auto_off_valid", 32'(seen), 32'd1);
    check_eq("auto_buttons", 32'(bus.buttons_out), 32'h0001);
    check_eq("auto_pressed", 32'(bus.pressed_out), 32'd0);
    s_lrise = lrise;
    wait_cycles(400);
    check_eq("auto_off_quiet", 32'(lrise - s_lrise), 32'd0);

    // Disconnected pads read as all released
    serial0 = 8'hFF;
    serial1 = 8'hFF;
    poll("disc", 16'h0000, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
